handshake_link: RTL and testbench



---
 rtl/handshake_link_if.sv | 25 ++
 rtl/handshake_link.sv | 94 +++++++++
 tb/tb_handshake_link.sv | 136 +++++++++++++
 3 files changed

// File: rtl/handshake_link_if.sv
// Channel bundle for handshake_link: async source word, the master's data/valid,
// the slave's ready and the received word/count. master = link side, slave = source/observer side.
`timescale 1ns/1ps
interface handshake_link_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
);
    logic [DATA_W-1:0] trans_data;
    logic              valid_var;
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] rx_data;
    logic [CNT_W-1:0]  rx_count;

    modport master (
        input  trans_data,
        output valid_var, data, valid, ready, rx_data, rx_count
    );

    modport slave (
        output trans_data,
        input  valid_var, data, valid, ready, rx_data, rx_count
    );
endinterface

// File: rtl/handshake_link.sv
// Point-to-point valid/ready link: master captures an async word, slave accepts and counts it.
// Define SLAVE_EARLY_READY_EN to let the slave raise ready from valid_var ahead of valid.
`timescale 1ns/1ps
module handshake_link #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    handshake_link_if.master  lnk
);
    typedef enum logic {IDLE, SEND} state_t;

    state_t            state, state_nxt;
    logic              armed, armed_nxt;
    logic [DATA_W-1:0] data_q, data_nxt;
    logic              valid_q, valid_nxt;
    logic              ready_q;
    logic [DATA_W-1:0] rx_data_q;
    logic [CNT_W-1:0]  rx_count_q;
    logic              src_nz;
    logic              hs;

    assign src_nz = |lnk.trans_data;
    assign hs     = valid_q && ready_q;

    // Master state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            armed   <= 1'b1;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            armed   <= armed_nxt;
            data_q  <= data_nxt;
            valid_q <= valid_nxt;
        end
    end

    // A zero sample re-arms; launching needs both a nonzero sample and armed,
    // so a held nonzero word yields exactly one transfer.
    always_comb begin
        state_nxt = state;
        armed_nxt = src_nz ? armed : 1'b1;
        data_nxt  = data_q;
        valid_nxt = valid_q;
        case (state)
            IDLE: begin
                if (src_nz && armed) begin
                    data_nxt  = lnk.trans_data;
                    valid_nxt = 1'b1;
                    armed_nxt = 1'b0;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (hs) begin
                    valid_nxt = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Slave: ready drops on the handshake edge and is re-raised afterwards
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_q    <= 1'b0;
            rx_data_q  <= '0;
            rx_count_q <= '0;
        end else if (hs) begin
            ready_q    <= 1'b0;
            rx_data_q  <= data_q;
            rx_count_q <= rx_count_q + CNT_W'(1);
`ifdef SLAVE_EARLY_READY_EN
        end else if (valid_q || lnk.valid_var) begin
            ready_q <= 1'b1;
`else
        end else if (valid_q) begin
            ready_q <= 1'b1;
`endif
        end
    end

    assign lnk.valid_var = src_nz;
    assign lnk.data      = data_q;
    assign lnk.valid     = valid_q;
    assign lnk.ready     = ready_q;
    assign lnk.rx_data   = rx_data_q;
    assign lnk.rx_count  = rx_count_q;
endmodule

// File: tb/tb_handshake_link.sv
// Directed bench for handshake_link; expectations are hand-timed against a 10 ns clock
// (posedges at 5, 15, ...). Expected values follow SLAVE_EARLY_READY_EN when defined.
`timescale 1ns/1ps
module tb_handshake_link;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 8;
`ifdef SLAVE_EARLY_READY_EN
    localparam bit E = 1'b1;
`else
    localparam bit E = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   n_chk = 0;
    int   n_err = 0;

    handshake_link_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) lnk ();

    handshake_link #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .lnk   (lnk)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic at(input int t);
        #(t - $time);
    endtask

    task automatic chk_idle(input string tag, input logic [7:0] cnt, input logic [31:0] rxd);
        chk({tag, ".valid"},    lnk.valid, 0);
        chk({tag, ".rx_count"}, lnk.rx_count, cnt);
        chk({tag, ".rx_data"},  lnk.rx_data, rxd);
    endtask

    initial begin
        reset = 1'b1;
        lnk.trans_data = 32'h2022_0503;

        // Reset held with a nonzero source
        at(50);
        chk("rst.data", lnk.data, 0);
        chk("rst.valid", lnk.valid, 0);
        chk("rst.ready", lnk.ready, 0);
        chk("rst.rx_data", lnk.rx_data, 0);
        chk("rst.rx_count", lnk.rx_count, 0);
        chk("rst.valid_var", lnk.valid_var, 1);
        at(100); reset = 1'b0;
        at(107);
        chk("rel.data", lnk.data, 32'h2022_0503);
        chk("rel.valid", lnk.valid, 1);
        chk("rel.ready", lnk.ready, E ? 1 : 0);
        at(117);
        chk("rel.valid2", lnk.valid, E ? 0 : 1);
        chk("rel.ready2", lnk.ready, E ? 0 : 1);
        chk("rel.cnt2", lnk.rx_count, E ? 1 : 0);
        at(127);
        chk_idle("rel.done", 8'd1, 32'h2022_0503);
        chk("rel.ready3", lnk.ready, E ? 1 : 0);
        at(130); lnk.trans_data = '0;
        chk("idle.valid_var", lnk.valid_var, 0);

        // Reset while idle clears the slave record
        at(150); reset = 1'b1;
        at(152);
        chk("rst2.ready", lnk.ready, 0);
        at(160); reset = 1'b0;
        at(165);
        chk_idle("rst2", 8'd0, 32'h0);

        // Single-posedge pulse
        at(192); lnk.trans_data = 32'h2022_0503;
        at(197);
        chk("pulse.valid", lnk.valid, 1);
        chk("pulse.data", lnk.data, 32'h2022_0503);
        chk("pulse.ready", lnk.ready, E ? 1 : 0);
        at(202); lnk.trans_data = '0;
        at(207);
        chk("pulse.valid2", lnk.valid, E ? 0 : 1);
        chk("pulse.ready2", lnk.ready, E ? 0 : 1);
        chk("pulse.cnt2", lnk.rx_count, E ? 1 : 0);
        at(217);
        chk_idle("pulse.done", 8'd1, 32'h2022_0503);
        chk("pulse.ready3", lnk.ready, 0);

        // Held nonzero input launches exactly once
        at(402); lnk.trans_data = 32'h1000_0006;
        at(407);
        chk("held.valid", lnk.valid, 1);
        chk("held.data", lnk.data, 32'h1000_0006);
        at(457);
        chk_idle("held.done", 8'd2, 32'h1000_0006);
        chk("held.ready", lnk.ready, E ? 1 : 0);

        // Source change during SEND is ignored
        at(460); lnk.trans_data = '0;
        at(482); lnk.trans_data = 32'h1111_2222;
        at(486); lnk.trans_data = 32'hDEAD_BEEF;
        at(489);
        chk("mid.valid", lnk.valid, 1);
        chk("mid.data", lnk.data, 32'h1111_2222);
        at(507);
        chk_idle("mid.done", 8'd3, 32'h1111_2222);
        at(527);
        chk_idle("mid.norelaunch", 8'd3, 32'h1111_2222);

        // Reset in the middle of a transfer
        at(530); lnk.trans_data = '0;
        at(542); lnk.trans_data = 32'h0BAD_F00D;
        at(547);
        chk("abort.valid", lnk.valid, 1);
        chk("abort.ready", lnk.ready, E ? 1 : 0);
        at(548); reset = 1'b1;
        at(549);
        chk("abort.data", lnk.data, 0);
        chk("abort.valid2", lnk.valid, 0);
        chk("abort.ready2", lnk.ready, 0);
        chk_idle("abort", 8'd0, 32'h0);
        at(560); reset = 1'b0; lnk.trans_data = '0;
        at(577);
        chk_idle("abort.after", 8'd0, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
